// File: rtl/slicem_ctrl_pkg.sv
// Shared types for the slicem write controller: FSM encoding and bit-counter width.
package slicem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } wr_state_e;

  localparam int WORD_W_DEF = 8;

  // A one-bit word still needs a one-bit counter.
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W_DEF = cnt_w(WORD_W_DEF);

endpackage

// File: rtl/slicem_wr_arb.sv
// NUM_REQ-way one-hot grant for the slicem write port.
// SLICEM_WCTRL_RR_EN selects round-robin; otherwise fixed priority (lowest index wins).
module slicem_wr_arb
  import slicem_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic               i_accept,
  output logic [NUM_REQ-1:0] o_grant
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_lo_idx;
  logic [PW-1:0] w_hi_idx;
  logic [PW-1:0] w_gidx;
  logic          w_any;
  logic          w_hi;

  // Two passes: lowest valid at or above the pointer, else lowest valid overall.
  always_comb begin
    w_lo_idx = '0;
    w_hi_idx = '0;
    w_any    = 1'b0;
    w_hi     = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_valid[i]) begin
        w_lo_idx = PW'(i);
        w_any    = 1'b1;
        if (PW'(i) >= r_ptr) begin
          w_hi_idx = PW'(i);
          w_hi     = 1'b1;
        end
      end
    end
    w_gidx = w_hi ? w_hi_idx : w_lo_idx;
    for (int i = 0; i < NUM_REQ; i++) begin
      o_grant[i] = w_any && (PW'(i) == w_gidx);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_accept) begin
`ifdef SLICEM_WCTRL_RR_EN
      r_ptr <= (w_gidx == PW'(NUM_REQ - 1)) ? '0 : w_gidx + PW'(1);
`else
      r_ptr <= '0;
`endif
    end
  end

endmodule

// File: rtl/slicem_write_ctrl.sv
// Serialises NUM_REQ word requests into single-bit slicem LUT-RAM writes.
// Arbitration is fixed priority unless SLICEM_WCTRL_RR_EN is defined (round-robin).
module slicem_write_ctrl
  import slicem_ctrl_pkg::*;
#(
  parameter int S_XX_BASE = 4,
  parameter int NUM_LUTS  = 4,
  parameter int MUX_LVLS  = $clog2(NUM_LUTS),
  parameter int WORD_W    = 8,
  parameter int NUM_REQ   = 2
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  output logic [NUM_REQ-1:0]              o_req_ready,
  input  logic [NUM_REQ*MUX_LVLS-1:0]     i_req_lut,
  input  logic [NUM_REQ-1:0]              i_req_sel,
  input  logic [NUM_REQ*S_XX_BASE-1:0]    i_req_base,
  input  logic [NUM_REQ*WORD_W-1:0]       i_req_data,
  output logic [NUM_REQ-1:0]              o_rsp_done,
  input  logic                            i_cfg_busy,
  output logic [2*S_XX_BASE*NUM_LUTS-1:0] o_luts_in,
  output logic [MUX_LVLS-1:0]             o_higher_order_addr,
  output logic                            o_write_lut_select,
  output logic                            o_data_in,
  output logic                            o_write_en,
  output logic                            o_wr_active
);

  localparam int CW = cnt_w(WORD_W);

  wr_state_e              r_state;
  logic [CW-1:0]          r_k;
  logic [MUX_LVLS-1:0]    r_lut;
  logic                   r_sel;
  logic [S_XX_BASE-1:0]   r_base;
  logic [S_XX_BASE-1:0]   r_addr;
  logic [WORD_W-1:0]      r_data;
  logic                   r_din;
  logic [NUM_REQ-1:0]     r_owner;
  logic [NUM_REQ-1:0]     r_done;
  logic                   r_active;

  logic [NUM_REQ-1:0]     w_grant;
  logic [NUM_REQ-1:0]     w_ready;
  logic                   w_accept;
  logic                   w_we;
  logic                   w_last;
  logic [CW-1:0]          w_k_next;
  logic [MUX_LVLS-1:0]    w_g_lut;
  logic                   w_g_sel;
  logic [S_XX_BASE-1:0]   w_g_base;
  logic [WORD_W-1:0]      w_g_data;

  slicem_wr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_req_valid),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  assign w_ready  = (i_rst_n && (r_state == ST_IDLE) && !i_cfg_busy) ? w_grant : '0;
  assign w_accept = |w_ready;
  assign w_we     = (r_state == ST_WRITE) && !i_cfg_busy;
  assign w_last   = (r_k == CW'(WORD_W - 1));
  assign w_k_next = r_k + CW'(1);

  // One-hot grant makes a plain priority scan an exact mux.
  always_comb begin
    w_g_lut  = '0;
    w_g_sel  = 1'b0;
    w_g_base = '0;
    w_g_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_g_lut  = i_req_lut[i*MUX_LVLS +: MUX_LVLS];
        w_g_sel  = i_req_sel[i];
        w_g_base = i_req_base[i*S_XX_BASE +: S_XX_BASE];
        w_g_data = i_req_data[i*WORD_W +: WORD_W];
      end
    end
  end

  // Address/data registers are preloaded one bit ahead so each write cycle sees bit k.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_k      <= '0;
      r_lut    <= '0;
      r_sel    <= 1'b0;
      r_base   <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_din    <= 1'b0;
      r_owner  <= '0;
      r_done   <= '0;
      r_active <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_lut    <= w_g_lut;
            r_sel    <= w_g_sel;
            r_base   <= w_g_base;
            r_data   <= w_g_data;
            r_owner  <= w_grant;
            r_k      <= '0;
            r_addr   <= w_g_base;
            r_din    <= w_g_data[0];
            r_active <= 1'b1;
            r_state  <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (w_we) begin
            if (w_last) begin
              r_done  <= r_owner;
              r_state <= ST_DONE;
            end else begin
              r_k    <= w_k_next;
              r_addr <= r_base + S_XX_BASE'(w_k_next);
              r_din  <= r_data[w_k_next];
            end
          end
        end
        ST_DONE: begin
          r_done   <= '0;
          r_active <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < 2 * NUM_LUTS; gi++) begin : g_luts_in
      assign o_luts_in[gi*S_XX_BASE +: S_XX_BASE] = r_addr;
    end
  endgenerate

  assign o_req_ready         = w_ready;
  assign o_rsp_done          = r_done;
  assign o_higher_order_addr = r_lut;
  assign o_write_lut_select  = r_sel;
  assign o_data_in           = r_din;
  assign o_write_en          = w_we;
  assign o_wr_active         = r_active;

endmodule

// File: tb/tb_slicem_write_ctrl.sv
// Directed bench for slicem_write_ctrl with a behavioural slicem LUT-RAM beside it.
`timescale 1ns/1ps
module tb_slicem_write_ctrl;

  localparam int S  = 4;
  localparam int NL = 4;
  localparam int ML = 2;
  localparam int W  = 8;
  localparam int NR = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*ML-1:0]  req_lut = '0;
  logic [NR-1:0]     req_sel = '0;
  logic [NR*S-1:0]   req_base = '0;
  logic [NR*W-1:0]   req_data = '0;
  logic [NR-1:0]     rsp_done;
  logic              cfg_busy = 1'b0;
  logic [2*S*NL-1:0] luts_in;
  logic [ML-1:0]     hoa;
  logic              wls;
  logic              din;
  logic              we;
  logic              act;

  int errors = 0;
  int checks = 0;

  logic        clr_mem = 1'b0;
  logic        mem [NL][2][16];
  logic [15:0] exp_mem [NL][2];
  logic [15:0] got_row;
  logic [4:0]  obs_addr [16];
  logic        obs_din [16];
  int          tab_a5_addr [8] = '{3, 4, 5, 6, 7, 8, 9, 10};
  int          tab_a5_din  [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
  int          tab_wr_addr [8] = '{14, 15, 0, 1, 2, 3, 4, 5};
`ifdef SLICEM_WCTRL_RR_EN
  int          exp_grant [4] = '{0, 1, 0, 1};
`else
  int          exp_grant [4] = '{0, 0, 0, 0};
`endif
  int          n;
  int          g;

  slicem_write_ctrl #(
    .S_XX_BASE(S), .NUM_LUTS(NL), .MUX_LVLS(ML), .WORD_W(W), .NUM_REQ(NR)
  ) dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_req_valid         (req_valid),
    .o_req_ready         (req_ready),
    .i_req_lut           (req_lut),
    .i_req_sel           (req_sel),
    .i_req_base          (req_base),
    .i_req_data          (req_data),
    .o_rsp_done          (rsp_done),
    .i_cfg_busy          (cfg_busy),
    .o_luts_in           (luts_in),
    .o_higher_order_addr (hoa),
    .o_write_lut_select  (wls),
    .o_data_in           (din),
    .o_write_en          (we),
    .o_wr_active         (act)
  );

  always #5 clk = ~clk;

  // slicem LUT-RAM: single-bit write addressed by the first luts_in field
  always @(posedge clk) begin
    if (clr_mem) begin
      for (int l = 0; l < NL; l++)
        for (int s = 0; s < 2; s++)
          for (int b = 0; b < 16; b++) mem[l][s][b] <= 1'b0;
    end else if (we) begin
      mem[hoa][wls][luts_in[S-1:0]] <= din;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic run_word(input int r, input int lut, input int sel, input int base,
                          input logic [W-1:0] data, input logic [63:0] busy_mask,
                          input int exp_done);
    int c;
    int k;
    int wait_n;
    logic [S-1:0] ea;
    cfg_busy = 1'b0;
    req_valid[r] = 1'b1;
    req_lut[r*ML +: ML] = ML'(lut);
    req_sel[r] = sel[0];
    req_base[r*S +: S] = S'(base);
    req_data[r*W +: W] = data;
    #1;
    wait_n = 0;
    while (!req_ready[r] && wait_n < 50) begin
      tick();
      wait_n++;
    end
    check_eq("ready", 64'(req_ready[r]), 64'd1);
    if (!req_ready[r]) begin
      req_valid[r] = 1'b0;
      return;
    end
    check_eq("ready_onehot", 64'(req_ready), 64'd1 << r);
    tick();
    req_valid[r] = 1'b0;
    req_lut[r*ML +: ML] = ML'($urandom);
    req_sel[r] = 1'($urandom);
    req_base[r*S +: S] = S'($urandom);
    req_data[r*W +: W] = W'($urandom);
    c = 1;
    k = 0;
    while (k < W && c < 64) begin
      cfg_busy = busy_mask[c];
      #1;
      check_eq("write_en", 64'(we), 64'(!busy_mask[c]));
      check_eq("wr_active", 64'(act), 64'd1);
      if (!busy_mask[c]) begin
        ea = S'((base + k) % 16);
        check_eq("luts_in", 64'(luts_in), 64'({(2*NL){ea}}));
        check_eq("data_in", 64'(din), 64'(data[k]));
        check_eq("hoa_sel", 64'({hoa, wls}), 64'({ML'(lut), sel[0]}));
        obs_addr[k] = {1'b0, luts_in[S-1:0]};
        obs_din[k] = din;
        k++;
      end
      tick();
      c++;
    end
    cfg_busy = 1'b0;
    #1;
    check_eq("done_cycle", 64'(c), 64'(exp_done));
    check_eq("rsp_done", 64'(rsp_done), 64'd1 << r);
    check_eq("we_in_done", 64'(we), 64'd0);
    tick();
    check_eq("done_clear", 64'({rsp_done, act}), 64'd0);
    $display("tx req=%0d lut=%0d sel=%0d base=%0d data=%02h done_at=T+%0d", r, lut, sel, base, data, c);
  endtask

  initial begin
    // reset state
    #12;
    check_eq("rst_outputs", 64'({req_ready, rsp_done, we, act, din, wls, hoa}), 64'd0);
    check_eq("rst_luts_in", 64'(luts_in), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_eq("idle_noreq", 64'(req_ready), 64'd0);

    // config load in IDLE suppresses ready
    cfg_busy = 1'b1;
    req_valid[0] = 1'b1;
    #1;
    check_eq("busy_noready", 64'(req_ready), 64'd0);
    tick();
    check_eq("busy_noaccept", 64'({act, req_ready}), 64'd0);
    cfg_busy = 1'b0;
    #1;
    check_eq("unbusy_ready", 64'(req_ready), 64'd1);

    // req 0: lut=2 sel=1 base=3 data=A5
    run_word(0, 2, 1, 3, 8'hA5, 64'd0, 9);
    for (int k = 0; k < 8; k++)
      check_eq("a5_table", 64'({obs_addr[k], obs_din[k]}), 64'({5'(tab_a5_addr[k]), 1'(tab_a5_din[k])}));

    // address wrap with base=14
    run_word(1, 3, 0, 14, 8'hFF, 64'd0, 9);
    for (int k = 0; k < 8; k++)
      check_eq("wrap_table", 64'(obs_addr[k]), 64'(tab_wr_addr[k]));

    // cfg_busy on T+3..T+5
    run_word(0, 1, 1, 5, 8'h3C, 64'h38, 12);

    // arbitration, both valid for 4 words
    do_reset();
    req_valid = 2'b11;
    req_lut = '0;
    req_base = '0;
    req_data = {8'h55, 8'h55};
    for (int w = 0; w < 4; w++) begin
      n = 0;
      while (req_ready == '0 && n < 50) begin
        tick();
        n++;
      end
      g = req_ready[1] ? 1 : 0;
      check_eq("arb_onehot", 64'($onehot(req_ready)), 64'd1);
      check_eq("arb_grant", 64'(g), 64'(exp_grant[w]));
      $display("tx arb word=%0d granted=%0d", w, g);
      tick();
      n = 0;
      while (rsp_done == '0 && n < 50) begin
        tick();
        n++;
      end
      check_eq("arb_done", 64'(rsp_done), 64'd1 << g);
      tick();
    end
    req_valid = '0;
    tick();

    // asynchronous reset mid-word at k=4
    req_valid[0] = 1'b1;
    req_lut[1:0] = 2'd1;
    req_sel[0] = 1'b0;
    req_base[3:0] = 4'd2;
    req_data[7:0] = 8'hFF;
    #1;
    check_eq("pre_rst_ready", 64'(req_ready), 64'd1);
    tick();
    req_valid[0] = 1'b0;
    repeat (4) tick();
    check_eq("pre_rst_we", 64'({we, luts_in[S-1:0]}), 64'({1'b1, 4'd6}));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_out", 64'({we, act, rsp_done, req_ready, din, hoa}), 64'd0);
    repeat (3) begin
      tick();
      check_eq("rst_no_done", 64'(rsp_done), 64'd0);
    end
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_idle", 64'({act, we}), 64'd0);
    $display("tx reset mid-word at k=4");
    run_word(0, 1, 0, 2, 8'hFF, 64'd0, 9);

    // slicem integration: 16 words covering every LUT and half
    clr_mem = 1'b1;
    tick();
    clr_mem = 1'b0;
    for (int l = 0; l < NL; l++)
      for (int s = 0; s < 2; s++) exp_mem[l][s] = '0;
    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] d;
      d = W'(8'h3C ^ (i * 37));
      run_word(i % 2, i % 4, (i / 4) % 2, (i / 8) * 8, d, 64'd0, 9);
      exp_mem[i % 4][(i / 4) % 2][((i / 8) * 8) +: 8] = d;
    end
    tick();
    for (int l = 0; l < NL; l++) begin
      for (int s = 0; s < 2; s++) begin
        for (int b = 0; b < 16; b++) got_row[b] = mem[l][s][b];
        check_eq("slicem_readback", 64'(got_row), 64'(exp_mem[l][s]));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
